// File: rtl/multi_axis_move_ctrl.sv
// Multi-axis move controller.
// Buffers absolute per-axis target commands in a small FIFO, converts each one
// into a relative move (pulse count + direction) against the last commanded
// position of that axis, and hands it to a shared pulse generator through a
// start/busy handshake.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   init_done           per-axis homing complete; all must be set to accept
//   cmd_valid/cmd_ready command handshake; cmd_axis, cmd_pos carry the target
//   pg_busy             pulse generator busy
//   pg_start            one-cycle start strobe; pg_axis/pg_pulses describe the move
//   dir                 per-axis direction (1 = reverse)
//   idle                FIFO empty and controller idle
//   err_axis            sticky: out-of-range axis command seen
//   limit_hit           sticky: target clamped to POS_MAX (soft-limit build only)
//
// Optional feature: define MOVE_CTRL_SOFT_LIMIT_EN to clamp targets to POS_MAX.
// Without it limit_hit is tied low and targets are used as given.
module multi_axis_move_ctrl #(
  parameter int unsigned NUM_AXES   = 6,
  parameter int unsigned POS_W      = 10,
  parameter int unsigned PULSE_W    = 16,
  parameter int unsigned SCALE      = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned POS_MAX    = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_AXES-1:0] init_done,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_axis,
  input  logic [POS_W-1:0]    cmd_pos,
  input  logic                pg_busy,
  output logic                pg_start,
  output logic [2:0]          pg_axis,
  output logic [PULSE_W-1:0]  pg_pulses,
  output logic [NUM_AXES-1:0] dir,
  output logic                idle,
  output logic                err_axis,
  output logic                limit_hit
);

  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PROD_W = POS_W + 6;  // SCALE fits in 6 bits
  localparam int unsigned WIDE_W = (PROD_W > PULSE_W) ? PROD_W : PULSE_W;

  typedef enum logic [1:0] {StIdle, StCalc, StIssue, StWait} state_e;

  // ---------------------------------------------------------------- FIFO
  logic [2:0]       fifo_axis [FIFO_DEPTH];
  logic [POS_W-1:0] fifo_pos  [FIFO_DEPTH];
  logic [ADDR_W:0]  wr_ptr_q, rd_ptr_q;
  logic             fifo_empty, fifo_full, push, pop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                      (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign cmd_ready  = !fifo_full && (&init_done);
  assign push       = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_axis[wr_ptr_q[ADDR_W-1:0]] <= cmd_axis;
      fifo_pos[wr_ptr_q[ADDR_W-1:0]]  <= cmd_pos;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------- state
  state_e               state_q, state_d;
  logic [2:0]           work_axis_q, work_axis_d;
  logic [POS_W-1:0]     work_pos_q, work_pos_d;
  logic [POS_W-1:0]     last_pos_q [NUM_AXES];
  logic [POS_W-1:0]     last_pos_d [NUM_AXES];
  logic [NUM_AXES-1:0]  dir_q, dir_d;
  logic [2:0]           pg_axis_q, pg_axis_d;
  logic [PULSE_W-1:0]   pg_pulses_q, pg_pulses_d;
  logic                 err_q, err_d;
  logic [1:0]           wait_cnt_q, wait_cnt_d;
  logic                 busy_seen_q, busy_seen_d;

  // ---------------------------------------------------------------- move calc
  logic                 axis_ok;
  logic [POS_W-1:0]     target, cur_last, delta;
  logic [WIDE_W-1:0]    prod;
  logic [PULSE_W-1:0]   pulses_sat;

  assign axis_ok = 32'(work_axis_q) < NUM_AXES;

`ifdef MOVE_CTRL_SOFT_LIMIT_EN
  logic over;
  logic lim_q, lim_d;
  assign over      = 32'(work_pos_q) > POS_MAX;
  assign target    = over ? POS_W'(POS_MAX) : work_pos_q;
  assign limit_hit = lim_q;
`else
  assign target    = work_pos_q;
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    cur_last = '0;
    for (int i = 0; i < NUM_AXES; i++) begin
      if (work_axis_q == 3'(i)) cur_last = last_pos_q[i];
    end
  end

  assign delta      = (target >= cur_last) ? (target - cur_last) : (cur_last - target);
  assign prod       = WIDE_W'(delta) * WIDE_W'(SCALE);
  assign pulses_sat = (prod > WIDE_W'({PULSE_W{1'b1}})) ? {PULSE_W{1'b1}} :
                                                          prod[PULSE_W-1:0];

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d     = state_q;
    work_axis_d = work_axis_q;
    work_pos_d  = work_pos_q;
    last_pos_d  = last_pos_q;
    dir_d       = dir_q;
    pg_axis_d   = pg_axis_q;
    pg_pulses_d = pg_pulses_q;
    err_d       = err_q;
    wait_cnt_d  = wait_cnt_q;
    busy_seen_d = busy_seen_q;
    pop         = 1'b0;
`ifdef MOVE_CTRL_SOFT_LIMIT_EN
    lim_d       = lim_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && !pg_busy) begin
          pop         = 1'b1;
          work_axis_d = fifo_axis[rd_ptr_q[ADDR_W-1:0]];
          work_pos_d  = fifo_pos[rd_ptr_q[ADDR_W-1:0]];
          state_d     = StCalc;
        end
      end
      StCalc: begin
        if (!axis_ok) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          for (int i = 0; i < NUM_AXES; i++) begin
            if (work_axis_q == 3'(i)) begin
              last_pos_d[i] = target;
              if (target < cur_last)      dir_d[i] = 1'b1;
              else if (target > cur_last) dir_d[i] = 1'b0;
            end
          end
`ifdef MOVE_CTRL_SOFT_LIMIT_EN
          if (over) lim_d = 1'b1;
`endif
          if (delta == '0) begin
            state_d = StIdle;
          end else begin
            pg_axis_d   = work_axis_q;
            pg_pulses_d = pulses_sat;
            state_d     = StIssue;
          end
        end
      end
      StIssue: begin
        wait_cnt_d  = '0;
        busy_seen_d = 1'b0;
        state_d     = StWait;
      end
      StWait: begin
        if (busy_seen_q) begin
          if (!pg_busy) state_d = StIdle;
        end else if (pg_busy) begin
          busy_seen_d = 1'b1;
        end else if (wait_cnt_q == 2'd3) begin
          // Generator never acknowledged: treat the move as done.
          state_d = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      work_axis_q <= '0;
      work_pos_q  <= '0;
      for (int i = 0; i < NUM_AXES; i++) last_pos_q[i] <= '0;
      dir_q       <= '0;
      pg_axis_q   <= '0;
      pg_pulses_q <= '0;
      err_q       <= 1'b0;
      wait_cnt_q  <= '0;
      busy_seen_q <= 1'b0;
`ifdef MOVE_CTRL_SOFT_LIMIT_EN
      lim_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      work_axis_q <= work_axis_d;
      work_pos_q  <= work_pos_d;
      last_pos_q  <= last_pos_d;
      dir_q       <= dir_d;
      pg_axis_q   <= pg_axis_d;
      pg_pulses_q <= pg_pulses_d;
      err_q       <= err_d;
      wait_cnt_q  <= wait_cnt_d;
      busy_seen_q <= busy_seen_d;
`ifdef MOVE_CTRL_SOFT_LIMIT_EN
      lim_q       <= lim_d;
`endif
    end
  end

  assign pg_start  = (state_q == StIssue);
  assign pg_axis   = pg_axis_q;
  assign pg_pulses = pg_pulses_q;
  assign dir       = dir_q;
  assign err_axis  = err_q;
  assign idle      = fifo_empty && (state_q == StIdle);

endmodule

// File: tb/tb_multi_axis_move_ctrl.sv
// Self-checking bench for multi_axis_move_ctrl: a default-parameter instance driven
// by a vector table, a scoreboard of expected moves and hand-written corner-case
// sequences, plus a second instance (SCALE=4, PULSE_W=10) for pulse saturation.
module tb_multi_axis_move_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  init_done;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_axis;
  logic [9:0]  cmd_pos;
  logic        pg_busy, pg_start;
  logic [2:0]  pg_axis;
  logic [15:0] pg_pulses;
  logic [5:0]  dir;
  logic        idle, err_axis, limit_hit;

  // Saturation instance
  logic        valid2, ready2, busy2, start2, idle2, err2, lim2;
  logic [2:0]  axis2, paxis2;
  logic [9:0]  pos2, ppulses2;
  logic [5:0]  dir2;

  always #5 clk = ~clk;

  multi_axis_move_ctrl dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_axis(cmd_axis), .cmd_pos(cmd_pos),
    .pg_busy(pg_busy), .pg_start(pg_start), .pg_axis(pg_axis), .pg_pulses(pg_pulses),
    .dir(dir), .idle(idle), .err_axis(err_axis), .limit_hit(limit_hit)
  );

  multi_axis_move_ctrl #(.SCALE(4), .PULSE_W(10)) dut_sat (
    .clk(clk), .rst(rst), .init_done(init_done),
    .cmd_valid(valid2), .cmd_ready(ready2), .cmd_axis(axis2), .cmd_pos(pos2),
    .pg_busy(busy2), .pg_start(start2), .pg_axis(paxis2), .pg_pulses(ppulses2),
    .dir(dir2), .idle(idle2), .err_axis(err2), .limit_hit(lim2)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Pulse generator model: busy for pg_len cycles after each start.
  int   pg_len = 3;
  bit   pg_auto = 1'b1;
  logic hold_busy = 1'b0;
  int   busy_cnt = 0;
  always @(negedge clk) begin
    if (pg_start && pg_auto) busy_cnt = pg_len;
    else if (busy_cnt > 0)   busy_cnt = busy_cnt - 1;
  end
  assign pg_busy = hold_busy | (busy_cnt != 0);

  // Scoreboard of expected moves, compared on every start strobe.
  typedef struct {
    logic [2:0]  axis;
    logic [15:0] pulses;
    logic        dirb;
  } exp_t;
  exp_t sb[$];
  int   starts = 0;
  int   exp_starts = 0;

  always @(negedge clk) begin
    if (pg_start) begin
      exp_t e;
      starts++;
      check("start_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pg_axis", 32'(pg_axis), 32'(e.axis));
        check("pg_pulses", 32'(pg_pulses), 32'(e.pulses));
        check("dir_at_start", 32'(dir[e.axis]), 32'(e.dirb));
      end
    end
  end

  task automatic expect_move(input logic [2:0] a, input logic [15:0] p, input logic d);
    exp_t e;
    e.axis = a; e.pulses = p; e.dirb = d;
    sb.push_back(e);
    exp_starts++;
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic send(input logic [2:0] a, input logic [9:0] p);
    bit acc = 1'b0;
    cmd_valid = 1'b1; cmd_axis = a; cmd_pos = p;
    for (int n = 0; n < 300; n++) begin
      if (cmd_ready) begin
        @(posedge clk);
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (acc) @(negedge clk);
    cmd_valid = 1'b0;
    check("accept", 32'(acc), 1);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (idle && !pg_busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_idle"}, 32'(ok), 1);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_pg_start"}, 32'(pg_start), 0);
    check({name, "_pg_axis"}, 32'(pg_axis), 0);
    check({name, "_pg_pulses"}, 32'(pg_pulses), 0);
    check({name, "_dir"}, 32'(dir), 0);
    check({name, "_err_axis"}, 32'(err_axis), 0);
    check({name, "_limit_hit"}, 32'(limit_hit), 0);
    check({name, "_idle"}, 32'(idle), 1);
  endtask

  task automatic send2(input logic [9:0] p, input logic [9:0] exp_p, input logic exp_d);
    bit seen = 1'b0;
    valid2 = 1'b1; axis2 = 3'd0; pos2 = p;
    check("sat_ready", 32'(ready2), 1);
    @(posedge clk);
    @(negedge clk);
    valid2 = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (start2) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("sat_start", 32'(seen), 1);
    check("sat_pulses", 32'(ppulses2), 32'(exp_p));
    check("sat_axis", 32'(paxis2), 0);
    check("sat_dir0", 32'(dir2[0]), 32'(exp_d));
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (idle2) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("sat_idle", 32'(seen), 1);
  endtask

  typedef struct {
    logic [2:0]  axis;
    logic [9:0]  pos;
    logic        move;
    logic [15:0] pulses;
    logic [5:0]  dirv;
    logic        err;
    logic        lim;
  } vec_t;
  vec_t tbl [11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int s0;
    bit seen;

    // Starting state: last_pos all 0 except axis 2 = 100 from the latency move.
    tbl[0]  = '{3'd2, 10'd40,   1'b1, 16'd60,   6'h04, 1'b0, 1'b0};
    tbl[1]  = '{3'd2, 10'd40,   1'b0, 16'd0,    6'h04, 1'b0, 1'b0};
    tbl[2]  = '{3'd0, 10'd5,    1'b1, 16'd5,    6'h04, 1'b0, 1'b0};
    tbl[3]  = '{3'd5, 10'd1023, 1'b1, 16'd1023, 6'h04, 1'b0, 1'b0};
    tbl[4]  = '{3'd5, 10'd0,    1'b1, 16'd1023, 6'h24, 1'b0, 1'b0};
    tbl[5]  = '{3'd7, 10'd300,  1'b0, 16'd0,    6'h24, 1'b1, 1'b0};
    tbl[6]  = '{3'd6, 10'd1,    1'b0, 16'd0,    6'h24, 1'b1, 1'b0};
    tbl[7]  = '{3'd2, 10'd50,   1'b1, 16'd10,   6'h20, 1'b1, 1'b0};
`ifdef MOVE_CTRL_SOFT_LIMIT_EN
    tbl[8]  = '{3'd1, 10'd1020, 1'b1, 16'd1000, 6'h20, 1'b1, 1'b1};
    tbl[9]  = '{3'd1, 10'd999,  1'b1, 16'd1,    6'h22, 1'b1, 1'b1};
    tbl[10] = '{3'd4, 10'd0,    1'b0, 16'd0,    6'h22, 1'b1, 1'b1};
`else
    tbl[8]  = '{3'd1, 10'd1020, 1'b1, 16'd1020, 6'h20, 1'b1, 1'b0};
    tbl[9]  = '{3'd1, 10'd999,  1'b1, 16'd21,   6'h22, 1'b1, 1'b0};
    tbl[10] = '{3'd4, 10'd0,    1'b0, 16'd0,    6'h22, 1'b1, 1'b0};
`endif

    rst = 1'b0; init_done = 6'h3F;
    cmd_valid = 1'b0; cmd_axis = '0; cmd_pos = '0;
    valid2 = 1'b0; axis2 = '0; pos2 = '0; busy2 = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    check("reset_ready", 32'(cmd_ready), 1);
    rst = 1'b1;
    @(negedge clk);

    // First move: start strobe in the third cycle after the accepting edge.
    expect_move(3'd2, 16'd100, 1'b0);
    send(3'd2, 10'd100);
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      if (pg_start) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    check("latency", lat, 3);
    wait_idle("first");

    // Vector table
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].move) expect_move(tbl[i].axis, tbl[i].pulses, tbl[i].dirv[tbl[i].axis]);
      send(tbl[i].axis, tbl[i].pos);
      wait_idle($sformatf("vec%0d", i));
      check($sformatf("vec%0d_starts", i), starts, exp_starts);
      check($sformatf("vec%0d_dir", i), 32'(dir), 32'(tbl[i].dirv));
      check($sformatf("vec%0d_err", i), 32'(err_axis), 32'(tbl[i].err));
      check($sformatf("vec%0d_lim", i), 32'(limit_hit), 32'(tbl[i].lim));
    end

    // Full FIFO while the generator is held busy.
    hold_busy = 1'b1;
    expect_move(3'd0, 16'd10, 1'b0);
    send(3'd0, 10'd15);
    expect_move(3'd3, 16'd7, 1'b0);
    send(3'd3, 10'd7);
    expect_move(3'd0, 16'd15, 1'b1);
    send(3'd0, 10'd0);
    expect_move(3'd3, 16'd2, 1'b0);
    send(3'd3, 10'd9);
    check("full_ready", 32'(cmd_ready), 0);
    check("full_not_idle", 32'(idle), 0);
    s0 = starts;
    cmd_valid = 1'b1; cmd_axis = 3'd2; cmd_pos = 10'd20;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("full_hold_ready", 32'(cmd_ready), 0);
    end
    check("busy_no_issue", starts, s0);
    expect_move(3'd2, 16'd30, 1'b1);
    hold_busy = 1'b0;
    send(3'd2, 10'd20);
    wait_idle("fifo");
    check("fifo_starts", starts, exp_starts);
    check("fifo_sb_empty", 32'(sb.size()), 0);
    check("fifo_dir", 32'(dir), 32'h27);

    // Homing incomplete on one axis blocks acceptance.
    init_done = 6'h3E;
    @(negedge clk);
    check("init_ready", 32'(cmd_ready), 0);
    init_done = 6'h3F;
    @(negedge clk);
    check("init_ready_back", 32'(cmd_ready), 1);

    // No busy acknowledge: move completes by timeout.
    pg_auto = 1'b0;
    expect_move(3'd4, 16'd3, 1'b0);
    send(3'd4, 10'd3);
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (pg_start) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("timeout_start", 32'(seen), 1);
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (idle) begin
        seen = 1'b1;
        break;
      end
    end
    check("timeout_idle", 32'(seen), 1);
    pg_auto = 1'b1;

    // Saturation on the second instance: 300*4 > 1023.
    send2(10'd300, 10'd1023, 1'b0);
    send2(10'd290, 10'd40, 1'b1);

    // Reset in the middle of a move.
    pg_len = 20;
    expect_move(3'd3, 16'd91, 1'b0);
    send(3'd3, 10'd100);
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (pg_start) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rst_move_start", 32'(seen), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b1;
    pg_len = 3;
    @(negedge clk);
    // last_pos must be cleared: 0 -> 4 forward, not 100 -> 4 reverse.
    expect_move(3'd3, 16'd4, 1'b0);
    send(3'd3, 10'd4);
    wait_idle("postrst");
    check("postrst_starts", starts, exp_starts);
    check("postrst_dir", 32'(dir), 0);
    check("end_sb_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
